// File: rtl/serial_adder_unit.sv
// -----------------------------------------------------------------------------
// serial_adder_unit
//
// Bit-serial adder/subtractor. A single full-adder slice is reused for WIDTH
// clock cycles, consuming one operand bit per cycle from the LSB upward.
// Subtraction is performed as A + ~B + 1 by inverting B on acceptance and
// seeding the carry with 1.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        synchronous reset, active-high, highest priority
//   in_valid   operand pair a/b/mode is presented
//   in_ready   unit can accept operands (high only in IDLE)
//   a, b       WIDTH-bit operands (unsigned or two's complement)
//   mode       0 = A+B, 1 = A-B (sampled only on acceptance)
//   busy       high while the serial computation is running
//   out_valid  result available
//   out_ready  consumer accepts the result
//   sum        WIDTH-bit result, modulo 2^WIDTH
//   cout       carry out (add) / no-borrow flag (sub: 1 when A >= B unsigned)
//   ovf        two's-complement overflow
//
// Latency: operands accepted at edge T run on edges T+1..T+WIDTH and
// out_valid is high from edge T+WIDTH. With out_ready tied high one operation
// completes every WIDTH+2 cycles.
// -----------------------------------------------------------------------------
module serial_adder_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mode,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    // The clamp keeps the counter declaration legal long enough for the
    // width error below to be the one that gets reported.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    generate
        if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
            $error("serial_adder_unit: WIDTH must be in the range 2..32");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-2:0] sum_sr;
    logic             carry;
    logic [CW-1:0]    bit_cnt;

    logic             s_bit;
    logic             c_next;
    logic [WIDTH-1:0] sum_next;

    // The full-adder slice. sum_sr holds the bits produced so far, already
    // right-aligned below the MSB, so prepending the current bit yields the
    // shifted sum register; on the final step that is the complete result.
    always_comb begin
        s_bit    = sa[0] ^ sb[0] ^ carry;
        c_next   = (sa[0] & sb[0]) | (sa[0] & carry) | (sb[0] & carry);
        sum_next = {s_bit, sum_sr};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sa        <= '0;
            sb        <= '0;
            sum_sr    <= '0;
            carry     <= 1'b0;
            bit_cnt   <= '0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    // Subtraction becomes A + ~B + 1: invert B here and seed
                    // the carry with mode, so RUN never needs to know the mode.
                    if (in_valid && in_ready) begin
                        sa       <= a;
                        sb       <= b ^ {WIDTH{mode}};
                        carry    <= mode;
                        bit_cnt  <= '0;
                        state    <= RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end

                RUN: begin
                    sa      <= sa >> 1;
                    sb      <= sb >> 1;
                    sum_sr  <= sum_next[WIDTH-1:1];
                    carry   <= c_next;
                    bit_cnt <= bit_cnt + CW'(1);
                    // On the MSB step, carry is the carry into the sign bit,
                    // so overflow is that carry-in XOR the final carry-out.
                    if (bit_cnt == LAST_BIT) begin
                        sum       <= sum_next;
                        cout      <= c_next;
                        ovf       <= carry ^ c_next;
                        bit_cnt   <= '0;
                        state     <= DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end

                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_unit.sv
// -----------------------------------------------------------------------------
// tb_serial_adder_unit
//
// Self-checking bench for serial_adder_unit. Three instances (WIDTH = 8, 2
// and 16) share the clock and reset. Expected results come from a wide
// arithmetic reference model and are queued when operands are accepted, then
// popped and compared when the unit presents a result.
// -----------------------------------------------------------------------------
module tb_serial_adder_unit;

    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    logic clk;
    logic rst;

    // WIDTH = 8 instance
    logic       in_valid, in_ready, mode, busy, out_valid, out_ready, cout, ovf;
    logic [7:0] a, b, sum;

    // WIDTH = 2 instance
    logic       in_valid2, in_ready2, mode2, busy2, out_valid2, out_ready2, cout2, ovf2;
    logic [1:0] a2, b2, sum2;

    // WIDTH = 16 instance
    logic        in_valid16, in_ready16, mode16, busy16, out_valid16, out_ready16, cout16, ovf16;
    logic [15:0] a16, b16, sum16;

    exp_t sb_q[$];
    int   passed;
    int   total;

    serial_adder_unit #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .mode(mode),
        .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    serial_adder_unit #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid2), .in_ready(in_ready2),
        .a(a2), .b(b2), .mode(mode2),
        .busy(busy2), .out_valid(out_valid2), .out_ready(out_ready2),
        .sum(sum2), .cout(cout2), .ovf(ovf2)
    );

    serial_adder_unit #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid16), .in_ready(in_ready16),
        .a(a16), .b(b16), .mode(mode16),
        .busy(busy16), .out_valid(out_valid16), .out_ready(out_ready16),
        .sum(sum16), .cout(cout16), .ovf(ovf16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain wide addition of A and (B or ~B) plus mode.
    function automatic exp_t model(input int w, input logic [31:0] x,
                                   input logic [31:0] y, input logic m);
        exp_t        r;
        logic [32:0] full;
        logic [31:0] mask;
        logic [31:0] yy;
        mask   = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        yy     = m ? (~y & mask) : (y & mask);
        full   = {1'b0, x & mask} + {1'b0, yy} + {32'd0, m};
        r.sum  = full[31:0] & mask;
        r.cout = full[w];
        r.ovf  = (x[w-1] == yy[w-1]) && (r.sum[w-1] != x[w-1]);
        return r;
    endfunction

    // Present one operand pair to the WIDTH=8 unit; returns one sample after
    // the accepting edge.
    task automatic applyStimulus(input logic [7:0] opa, input logic [7:0] opb,
                                 input logic m, input bit push);
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (in_ready !== 1'b1) begin
            total++;
            $display("[TB] FAIL accept_timeout in_ready=%b required=1", in_ready);
        end
        a = opa; b = opb; mode = m; in_valid = 1'b1;
        if (push) sb_q.push_back(model(8, {24'd0, opa}, {24'd0, opb}, m));
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Bounded wait for out_valid on the WIDTH=8 unit.
    task automatic wait_result8(input int budget);
        int n;
        n = 0;
        while (out_valid !== 1'b1 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        if (out_valid !== 1'b1) begin
            total++;
            $display("[TB] FAIL result_timeout out_valid=%b required=1", out_valid);
        end
    endtask

    task automatic release_result8;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        total++; if (in_ready !== 1'b1)  $display("[TB] FAIL reset_in_ready got=%b want=1", in_ready);   else passed++;
        total++; if (busy !== 1'b0)      $display("[TB] FAIL reset_busy got=%b want=0", busy);           else passed++;
        total++; if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid got=%b want=0", out_valid); else passed++;
        total++; if (sum !== 8'h00)      $display("[TB] FAIL reset_sum got=%h want=00", sum);            else passed++;
        total++; if (cout !== 1'b0)      $display("[TB] FAIL reset_cout got=%b want=0", cout);           else passed++;
        total++; if (ovf !== 1'b0)       $display("[TB] FAIL reset_ovf got=%b want=0", ovf);             else passed++;
    endtask

    task automatic test_add_latency;
        int   busy_cnt;
        int   lat;
        exp_t e;
        busy_cnt = 0;
        lat      = 0;
        applyStimulus(8'h3C, 8'h55, 1'b0, 1'b1);
        for (int k = 0; k < 20 && out_valid !== 1'b1; k++) begin
            if (busy === 1'b1) busy_cnt++;
            @(posedge clk); #1;
            lat++;
        end
        total++; if (lat != 8)        $display("[TB] FAIL latency got=%0d want=8", lat);          else passed++;
        total++; if (busy_cnt != 8)   $display("[TB] FAIL busy_cycles got=%0d want=8", busy_cnt); else passed++;
        total++; if (busy !== 1'b0)   $display("[TB] FAIL done_busy got=%b want=0", busy);        else passed++;
        total++; if (in_ready !== 1'b0) $display("[TB] FAIL done_in_ready got=%b want=0", in_ready); else passed++;
        e = sb_q.pop_front();
        total++; if ({24'd0, sum} !== e.sum) $display("[TB] FAIL add_sum got=%h want=%h", sum, e.sum[7:0]); else passed++;
        total++; if (cout !== e.cout) $display("[TB] FAIL add_cout got=%b want=%b", cout, e.cout); else passed++;
        total++; if (ovf !== e.ovf)   $display("[TB] FAIL add_ovf got=%b want=%b", ovf, e.ovf);    else passed++;
        release_result8();
        total++; if (out_valid !== 1'b0) $display("[TB] FAIL release_out_valid got=%b want=0", out_valid); else passed++;
        total++; if (in_ready !== 1'b1)  $display("[TB] FAIL release_in_ready got=%b want=1", in_ready);   else passed++;
    endtask

    task automatic test_arith;
        logic [7:0] ta [4];
        logic [7:0] tb [4];
        logic       tm [4];
        exp_t       e;
        ta = '{8'hFF, 8'h10, 8'h80, 8'h7F};
        tb = '{8'h01, 8'h20, 8'h01, 8'h01};
        tm = '{1'b0,  1'b1,  1'b1,  1'b0};
        for (int i = 0; i < 4; i++) begin
            applyStimulus(ta[i], tb[i], tm[i], 1'b1);
            wait_result8(30);
            e = sb_q.pop_front();
            total++; if ({24'd0, sum} !== e.sum) $display("[TB] FAIL arith%0d_sum got=%h want=%h", i, sum, e.sum[7:0]); else passed++;
            total++; if (cout !== e.cout) $display("[TB] FAIL arith%0d_cout got=%b want=%b", i, cout, e.cout); else passed++;
            total++; if (ovf !== e.ovf)   $display("[TB] FAIL arith%0d_ovf got=%b want=%b", i, ovf, e.ovf);    else passed++;
            release_result8();
        end
    endtask

    task automatic test_backpressure;
        exp_t e;
        applyStimulus(8'h12, 8'h34, 1'b0, 1'b1);
        // Operands offered while running must be ignored.
        a = 8'hAA; b = 8'h55; mode = 1'b1; in_valid = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        wait_result8(30);
        e = sb_q.pop_front();
        a = 8'hF0; b = 8'h0F; mode = 1'b1; in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            total++; if (out_valid !== 1'b1) $display("[TB] FAIL hold%0d_out_valid got=%b want=1", k, out_valid); else passed++;
            total++; if ({24'd0, sum} !== e.sum) $display("[TB] FAIL hold%0d_sum got=%h want=%h", k, sum, e.sum[7:0]); else passed++;
            total++; if (cout !== e.cout) $display("[TB] FAIL hold%0d_cout got=%b want=%b", k, cout, e.cout); else passed++;
            total++; if (ovf !== e.ovf)   $display("[TB] FAIL hold%0d_ovf got=%b want=%b", k, ovf, e.ovf);    else passed++;
            total++; if (in_ready !== 1'b0) $display("[TB] FAIL hold%0d_in_ready got=%b want=0", k, in_ready); else passed++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        release_result8();
        total++; if (out_valid !== 1'b0) $display("[TB] FAIL bp_release_out_valid got=%b want=0", out_valid); else passed++;
        applyStimulus(8'h05, 8'h03, 1'b0, 1'b1);
        wait_result8(30);
        e = sb_q.pop_front();
        total++; if ({24'd0, sum, cout, ovf} !== {e.sum, e.cout, e.ovf})
            $display("[TB] FAIL bp_next got=%h/%b/%b want=%h/%b/%b", sum, cout, ovf, e.sum[7:0], e.cout, e.ovf);
        else passed++;
        release_result8();
    endtask

    task automatic test_reset_mid;
        bit   saw_valid;
        exp_t e;
        saw_valid = 1'b0;
        applyStimulus(8'h77, 8'h11, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total++; if (in_ready !== 1'b1)  $display("[TB] FAIL mid_rst_in_ready got=%b want=1", in_ready);   else passed++;
        total++; if (busy !== 1'b0)      $display("[TB] FAIL mid_rst_busy got=%b want=0", busy);           else passed++;
        total++; if (out_valid !== 1'b0) $display("[TB] FAIL mid_rst_out_valid got=%b want=0", out_valid); else passed++;
        total++; if ({sum, cout, ovf} !== 10'd0) $display("[TB] FAIL mid_rst_result got=%h/%b/%b want=00/0/0", sum, cout, ovf); else passed++;
        for (int k = 0; k < 15; k++) begin
            if (out_valid === 1'b1) saw_valid = 1'b1;
            @(posedge clk); #1;
        end
        total++; if (saw_valid) $display("[TB] FAIL mid_rst_no_result got=1 want=0"); else passed++;
        applyStimulus(8'h01, 8'h01, 1'b0, 1'b1);
        wait_result8(30);
        e = sb_q.pop_front();
        total++; if ({24'd0, sum} !== e.sum) $display("[TB] FAIL post_rst_sum got=%h want=%h", sum, e.sum[7:0]); else passed++;
        total++; if ({cout, ovf} !== {e.cout, e.ovf}) $display("[TB] FAIL post_rst_flags got=%b%b want=%b%b", cout, ovf, e.cout, e.ovf); else passed++;
        release_result8();
    endtask

    task automatic test_back_to_back;
        int   acc, rcv, cyc, last_acc;
        bit   pend;
        exp_t e;
        acc = 0; rcv = 0; cyc = 0; last_acc = -1; pend = 1'b0;
        out_ready = 1'b1; in_valid = 1'b1;
        a = 8'($urandom); b = 8'($urandom); mode = 1'($urandom_range(0, 1));
        while (rcv < 6 && cyc < 300) begin
            if (out_valid === 1'b1) begin
                total++;
                if (sb_q.size() == 0) $display("[TB] FAIL b2b_unexpected got=%h want=none", sum);
                else begin
                    e = sb_q.pop_front();
                    if ({24'd0, sum, cout, ovf} !== {e.sum, e.cout, e.ovf})
                        $display("[TB] FAIL b2b%0d got=%h/%b/%b want=%h/%b/%b", rcv, sum, cout, ovf, e.sum[7:0], e.cout, e.ovf);
                    else passed++;
                end
                rcv++;
            end
            if (in_ready === 1'b1 && in_valid === 1'b1) begin
                sb_q.push_back(model(8, {24'd0, a}, {24'd0, b}, mode));
                if (last_acc >= 0) begin
                    total++;
                    if (cyc - last_acc != 10) $display("[TB] FAIL b2b_spacing got=%0d want=10", cyc - last_acc);
                    else passed++;
                end
                last_acc = cyc;
                acc++;
                pend = 1'b1;
            end
            @(posedge clk); #1;
            cyc++;
            if (pend) begin
                pend = 1'b0;
                if (acc < 6) begin
                    a = 8'($urandom); b = 8'($urandom); mode = 1'($urandom_range(0, 1));
                end else in_valid = 1'b0;
            end
        end
        if (rcv < 6) begin
            total++;
            $display("[TB] FAIL b2b_timeout got=%0d results want=6", rcv);
        end
        in_valid = 1'b0; out_ready = 1'b0;
        sb_q.delete();
    endtask

    task automatic test_random_w2;
        int   acc, rcv, cyc;
        bit   pend;
        exp_t e;
        acc = 0; rcv = 0; cyc = 0; pend = 1'b0;
        out_ready2 = 1'b1; in_valid2 = 1'b1;
        a2 = 2'($urandom); b2 = 2'($urandom); mode2 = 1'($urandom_range(0, 1));
        while (rcv < 1000 && cyc < 4200) begin
            if (out_valid2 === 1'b1) begin
                total++;
                if (sb_q.size() == 0) $display("[TB] FAIL w2_unexpected got=%h want=none", sum2);
                else begin
                    e = sb_q.pop_front();
                    if ({30'd0, sum2, cout2, ovf2, busy2} !== {e.sum, e.cout, e.ovf, 1'b0})
                        $display("[TB] FAIL w2_op%0d got=%h/%b/%b want=%h/%b/%b", rcv, sum2, cout2, ovf2, e.sum[1:0], e.cout, e.ovf);
                    else passed++;
                end
                rcv++;
            end
            if (in_ready2 === 1'b1 && in_valid2 === 1'b1) begin
                sb_q.push_back(model(2, {30'd0, a2}, {30'd0, b2}, mode2));
                acc++;
                pend = 1'b1;
            end
            @(posedge clk); #1;
            cyc++;
            if (pend) begin
                pend = 1'b0;
                if (acc < 1000) begin
                    a2 = 2'($urandom); b2 = 2'($urandom); mode2 = 1'($urandom_range(0, 1));
                end else in_valid2 = 1'b0;
            end
        end
        if (rcv < 1000) begin
            total++;
            $display("[TB] FAIL w2_timeout got=%0d results want=1000", rcv);
        end
        in_valid2 = 1'b0; out_ready2 = 1'b0;
        sb_q.delete();
    endtask

    task automatic test_random_w16;
        int   acc, rcv, cyc;
        bit   pend;
        exp_t e;
        acc = 0; rcv = 0; cyc = 0; pend = 1'b0;
        out_ready16 = 1'b1; in_valid16 = 1'b1;
        a16 = 16'($urandom); b16 = 16'($urandom); mode16 = 1'($urandom_range(0, 1));
        while (rcv < 1000 && cyc < 18200) begin
            if (out_valid16 === 1'b1) begin
                total++;
                if (sb_q.size() == 0) $display("[TB] FAIL w16_unexpected got=%h want=none", sum16);
                else begin
                    e = sb_q.pop_front();
                    if ({16'd0, sum16, cout16, ovf16, busy16} !== {e.sum, e.cout, e.ovf, 1'b0})
                        $display("[TB] FAIL w16_op%0d got=%h/%b/%b want=%h/%b/%b", rcv, sum16, cout16, ovf16, e.sum[15:0], e.cout, e.ovf);
                    else passed++;
                end
                rcv++;
            end
            if (in_ready16 === 1'b1 && in_valid16 === 1'b1) begin
                sb_q.push_back(model(16, {16'd0, a16}, {16'd0, b16}, mode16));
                acc++;
                pend = 1'b1;
            end
            @(posedge clk); #1;
            cyc++;
            if (pend) begin
                pend = 1'b0;
                if (acc < 1000) begin
                    a16 = 16'($urandom); b16 = 16'($urandom); mode16 = 1'($urandom_range(0, 1));
                end else in_valid16 = 1'b0;
            end
        end
        if (rcv < 1000) begin
            total++;
            $display("[TB] FAIL w16_timeout got=%0d results want=1000", rcv);
        end
        in_valid16 = 1'b0; out_ready16 = 1'b0;
        sb_q.delete();
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rst = 1'b1;
        in_valid = 1'b0;   out_ready = 1'b0;   a = '0;   b = '0;   mode = 1'b0;
        in_valid2 = 1'b0;  out_ready2 = 1'b0;  a2 = '0;  b2 = '0;  mode2 = 1'b0;
        in_valid16 = 1'b0; out_ready16 = 1'b0; a16 = '0; b16 = '0; mode16 = 1'b0;

        test_reset();
        test_add_latency();
        test_arith();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_random_w2();
        test_random_w16();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
